// File: rtl/rr_arb2_sel_pkg.sv
// Shared select/state encodings and the two-way round-robin pick rule
// used by the rr_arb2_sel arbiter.
package rr_arb2_sel_pkg;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // A lone requester always wins; on contention the priority holder wins;
    // with no requester the select rests on the priority holder.
    function automatic logic arb_pick(input logic v0, input logic v1, input logic prio);
        logic sel;
        sel = prio;
        if (v0 && !v1) begin
            sel = SEL_I0;
        end else if (v1 && !v0) begin
            sel = SEL_I1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer cell; sel=0 passes i0, sel=1 passes i1.
module mux2to1 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/rr_arb2_sel.sv
// Two-requester round-robin arbiter driving a mux2to1 bank, followed by a
// single valid/ready output register that can drain and refill each clock.
module rr_arb2_sel
    import rr_arb2_sel_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             grant_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    state_e           r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_sel;

    logic             w_grant;
    logic             w_load;
    logic [WIDTH-1:0] w_mux_y;

    // Grant and acceptance; readies are forced low while reset is asserted
    // so no requester believes a transfer happened during reset.
    always_comb begin
        w_grant   = arb_pick(in0_valid, in1_valid, r_prio);
        w_load    = (in0_valid | in1_valid) & ((r_state == ST_EMPTY) | out_ready);
        in0_ready = w_load & (w_grant == SEL_I0) & ~rst;
        in1_ready = w_load & (w_grant == SEL_I1) & ~rst;
    end

    assign grant_sel = w_grant;

    for (genvar k = 0; k < WIDTH; k++) begin : g_mux
        mux2to1 u_mux (
            .i0  (in0_data[k]),
            .i1  (in1_data[k]),
            .sel (w_grant),
            .y   (w_mux_y[k])
        );
    end

    // Output register; prio moves only when a word is actually loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_prio     <= SEL_I0;
            r_out_data <= '0;
            r_out_sel  <= SEL_I0;
        end else if (w_load) begin
            r_state    <= ST_FULL;
            r_out_data <= w_mux_y;
            r_out_sel  <= w_grant;
            r_prio     <= ~w_grant;
        end else if (out_ready) begin
            r_state    <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb2_sel.sv
// Self-checking bench for rr_arb2_sel: directed scenarios plus a randomized
// run scored against a queue-based transaction model.
module tb_rr_arb2_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in1_valid;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready;
    logic       grant_sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sel;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb2_sel #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .grant_sel (grant_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = 8'h00; in1_data = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA5; in1_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low got %b%b want 00", in0_ready, in1_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got v=%b d=%h s=%b want v=0 d=00 s=0", out_valid, out_data, out_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in0_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b want 1", in0_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL reset_load got v=%b d=%h want v=1 d=a5", out_valid, out_data);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0 ||
            in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%h s=%b r=%b%b want v=0 d=00 s=0 r=00",
                     out_valid, out_data, out_sel, in0_ready, in1_ready);
        end
        @(negedge clk);
        rst = 1'b0; in0_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h3C; out_ready = 1'b1;
        #1;
        checks++;
        if (grant_sel !== 1'b1 || in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++; $display("FAIL single_grant got g=%b r0=%b r1=%b want g=1 r0=0 r1=1", grant_sel, in0_ready, in1_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 1'b1) begin
            errors++; $display("FAIL single_out got v=%b d=%h s=%b want v=1 d=3c s=1", out_valid, out_data, out_sel);
        end
        @(negedge clk);
        in0_valid = 1'b1; in0_data = 8'h44; in1_valid = 1'b1;
        #1;
        checks++;
        if (grant_sel !== 1'b0) begin
            errors++; $display("FAIL single_prio_after got %b want 0", grant_sel);
        end
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_data !== exp_d[i] || out_sel !== 1'(i % 2) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL contention_%0d got d=%h s=%b v=%b want d=%h s=%0d v=1",
                         i, out_data, out_sel, out_valid, exp_d[i], i % 2);
            end
        end
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_data !== 8'h11 ||
                out_sel !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold_%0d got r=%b%b d=%h s=%b v=%b want r=00 d=11 s=0 v=1",
                         i, in0_ready, in1_ready, out_data, out_sel, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (grant_sel !== 1'b1 || in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++; $display("FAIL backpressure_release got g=%b r=%b%b want g=1 r=01", grant_sel, in0_ready, in1_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 8'h22 || out_sel !== 1'b1) begin
            errors++; $display("FAIL backpressure_next got d=%h s=%b want d=22 s=1", out_data, out_sel);
        end
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h5A; out_ready = 1'b0;
        @(negedge clk);
        in0_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (grant_sel !== 1'b1 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL drain_idle got g=%b r=%b%b want g=1 r=00", grant_sel, in0_ready, in1_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A) begin
            errors++; $display("FAIL drain_empty got v=%b d=%h want v=0 d=5a", out_valid, out_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant_sel !== 1'b1) begin
            errors++; $display("FAIL drain_prio got %b want 1", grant_sel);
        end
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic       m_prio;
        logic       p0, p1;
        logic       exp_g, exp_load;
        do_reset();
        m_prio = 1'b0; p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!p0) begin in0_valid = 1'($urandom_range(0, 1)); in0_data = 8'($urandom); end
            if (!p1) begin in1_valid = 1'($urandom_range(0, 1)); in1_data = 8'($urandom); end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in0_valid && !in1_valid)      exp_g = 1'b0;
            else if (in1_valid && !in0_valid) exp_g = 1'b1;
            else                              exp_g = m_prio;
            exp_load = (in0_valid || in1_valid) && (q.size() == 0 || out_ready);
            checks++;
            if (grant_sel !== exp_g) begin
                errors++; $display("FAIL rand_grant cyc %0d got %b want %b", c, grant_sel, exp_g);
            end
            checks++;
            if (in0_ready !== (exp_load && !exp_g) || in1_ready !== (exp_load && exp_g)) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b%b want %b%b", c, in0_ready, in1_ready,
                                   exp_load && !exp_g, exp_load && exp_g);
            end
            checks++;
            if (in0_ready && in1_ready) begin
                errors++; $display("FAIL rand_both_ready cyc %0d got 11 want not 11", c);
            end
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_out_valid cyc %0d got %b want %b", c, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_sel, out_data} !== q[0]) begin
                    errors++; $display("FAIL rand_out_word cyc %0d got %h want %h", c, {out_sel, out_data}, q[0]);
                end
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (exp_load) begin
                q.push_back({exp_g, exp_g ? in1_data : in0_data});
                m_prio = ~exp_g;
            end
            p0 = in0_valid && !(exp_load && !exp_g);
            p1 = in1_valid && !(exp_load && exp_g);
        end
        @(negedge clk);
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = 8'h00; in1_data = 8'h00;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
